// File: rtl/sys_rst_pkg.sv
// Shared types for the reset sequencer: FSM states, reset-cause codes
// and the counter-width helper.
package sys_rst_pkg;

    typedef enum logic [1:0] {
        HOLD,
        WAIT_LOCK,
        STRETCH,
        RUN
    } state_t;

    localparam logic [1:0] RC_POR  = 2'b00;
    localparam logic [1:0] RC_BTN  = 2'b01;
    localparam logic [1:0] RC_LOCK = 2'b10;

    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sys_rst_filter.sv
// Synchroniser plus stability counter; the output level follows the input
// only after RISE_CYC / FALL_CYC consecutive cycles at the new level.
module sys_rst_filter
    import sys_rst_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   RISE_CYC    = 4,
    parameter int   FALL_CYC    = 1,
    parameter logic INIT_LVL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int MAXC = (RISE_CYC > FALL_CYC) ? RISE_CYC : FALL_CYC;
    localparam int W    = cnt_w(MAXC);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [W-1:0]           cnt_q;
    logic [W-1:0]           lim;
    logic                   s;

    assign s   = sync_q[SYNC_STAGES-1];
    assign lim = dout ? W'(FALL_CYC - 1) : W'(RISE_CYC - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{INIT_LVL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            dout  <= INIT_LVL;
        end else if (s == dout) begin
            cnt_q <= '0;
        end else if (cnt_q == lim) begin
            cnt_q <= '0;
            dout  <= s;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/sys_reset_sequencer.sv
// Power-on / button / PLL-lock reset sequencer for the core and DDR3 clock.
// Define SYS_RST_HEARTBEAT_EN to blink led0 from a divider while running.
module sys_reset_sequencer
    import sys_rst_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYC    = 500000,
    parameter int LOCK_STABLE_CYC = 1024,
    parameter int RST_STRETCH_CYC = 4096,
    parameter int HB_DIV_LOG2     = 24
) (
    input  logic       io_axiClk,
    input  logic       io_asyncReset,
    input  logic       button_n,
    input  logic       pll_lock,
    output logic       core_reset,
    output logic       ddr_clk_en,
    output logic       led0,
    output logic [1:0] rst_cause,
    output logic [7:0] lock_loss_cnt
);

    localparam int          SW   = cnt_w(RST_STRETCH_CYC);
    localparam logic [SW-1:0] LAST = SW'(RST_STRETCH_CYC - 1);

    logic          btn_lvl;
    logic          lock_lvl;
    logic          press;
    logic          lost;
    state_t        state_q, state_d;
    logic [SW-1:0] str_q, str_d;
    logic [1:0]    cause_d;
    logic [7:0]    loss_d;

    sys_rst_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .RISE_CYC    (DEBOUNCE_CYC),
        .FALL_CYC    (DEBOUNCE_CYC),
        .INIT_LVL    (1'b1)
    ) u_btn_filt (
        .clk  (io_axiClk),
        .rst  (io_asyncReset),
        .din  (button_n),
        .dout (btn_lvl)
    );

    sys_rst_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .RISE_CYC    (LOCK_STABLE_CYC),
        .FALL_CYC    (1),
        .INIT_LVL    (1'b0)
    ) u_lock_filt (
        .clk  (io_axiClk),
        .rst  (io_asyncReset),
        .din  (pll_lock),
        .dout (lock_lvl)
    );

    always_comb begin
        state_d = state_q;
        str_d   = (state_q == STRETCH) ? str_q : '0;
        cause_d = rst_cause;
        loss_d  = lock_loss_cnt;
        press   = !btn_lvl;
        lost    = !lock_lvl && (state_q == STRETCH || state_q == RUN);
        // Button beats lock loss for the cause, but the loss is still counted
        if (state_q != HOLD && (press || lost)) begin
            state_d = HOLD;
            cause_d = press ? RC_BTN : RC_LOCK;
            if (lost && lock_loss_cnt != 8'hFF) begin
                loss_d = lock_loss_cnt + 8'd1;
            end
        end else begin
            unique case (state_q)
                HOLD:      if (btn_lvl) state_d = WAIT_LOCK;
                WAIT_LOCK: if (lock_lvl) state_d = STRETCH;
                STRETCH: begin
                    if (str_q == LAST) state_d = RUN;
                    else str_d = str_q + SW'(1);
                end
                RUN: ;
            endcase
        end
    end

    always_ff @(posedge io_axiClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            state_q       <= HOLD;
            str_q         <= '0;
            rst_cause     <= RC_POR;
            lock_loss_cnt <= '0;
            core_reset    <= 1'b1;
            ddr_clk_en    <= 1'b0;
        end else begin
            state_q       <= state_d;
            str_q         <= str_d;
            rst_cause     <= cause_d;
            lock_loss_cnt <= loss_d;
            core_reset    <= (state_q != RUN);
            ddr_clk_en    <= (state_q == STRETCH) || (state_q == RUN);
        end
    end

`ifdef SYS_RST_HEARTBEAT_EN
    logic [HB_DIV_LOG2-1:0] hb_q;

    always_ff @(posedge io_axiClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            hb_q <= '0;
            led0 <= 1'b0;
        end else begin
            hb_q <= (state_q == RUN) ? hb_q + HB_DIV_LOG2'(1) : '0;
            led0 <= (state_q == RUN) && hb_q[HB_DIV_LOG2-1];
        end
    end
`else
    always_ff @(posedge io_axiClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            led0 <= 1'b0;
        end else begin
            led0 <= (state_q == RUN) && (HB_DIV_LOG2 > 0);
        end
    end
`endif

endmodule

// File: tb/tb_sys_reset_sequencer.sv
// Bench for sys_reset_sequencer: directed scenarios plus random stimulus,
// all outputs compared each cycle against a behavioural model.
module tb_sys_reset_sequencer;

    localparam int SYNC = 2;
    localparam int DEB  = 8;
    localparam int LCK  = 4;
    localparam int STR  = 16;
    localparam int HB   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       button_n = 1'b1;
    logic       pll_lock = 1'b0;
    logic       core_reset, ddr_clk_en, led0;
    logic [1:0] rst_cause;
    logic [7:0] lock_loss_cnt;

    int checks = 0;
    int errors = 0;

    sys_reset_sequencer #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYC    (DEB),
        .LOCK_STABLE_CYC (LCK),
        .RST_STRETCH_CYC (STR),
        .HB_DIV_LOG2     (HB)
    ) dut (
        .io_axiClk     (clk),
        .io_asyncReset (rst),
        .button_n      (button_n),
        .pll_lock      (pll_lock),
        .core_reset    (core_reset),
        .ddr_clk_en    (ddr_clk_en),
        .led0          (led0),
        .rst_cause     (rst_cause),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    // model: delay lines, run lengths, phase 0..3 = hold/wait/stretch/run
    bit bp[SYNC];
    bit lp[SYNC];
    bit fb, fl;
    int rb, rl;
    int phase, str_n, hb_n;
    int m_cause, m_cnt;
    bit m_core, m_ddr, m_led;

    task m_reset();
        for (int i = 0; i < SYNC; i++) begin
            bp[i] = 1'b1;
            lp[i] = 1'b0;
        end
        fb = 1'b1; fl = 1'b0; rb = 0; rl = 0;
        phase = 0; str_n = 0; hb_n = 0;
        m_cause = 0; m_cnt = 0;
        m_core = 1'b1; m_ddr = 1'b0; m_led = 1'b0;
    endtask

    task automatic filt(inout bit lvl, inout int run, input bit s,
                        input int nr, input int nf);
        if (s == lvl) run = 0;
        else if (run + 1 >= (lvl ? nf : nr)) begin
            lvl = s;
            run = 0;
        end else run++;
    endtask

    task m_step();
        bit press, lost, sb, sl;
        m_core = (phase != 3);
        m_ddr  = (phase >= 2);
`ifdef SYS_RST_HEARTBEAT_EN
        m_led = (phase == 3) && (hb_n >= (1 << (HB - 1)));
        hb_n  = (phase == 3) ? (hb_n + 1) % (1 << HB) : 0;
`else
        m_led = (phase == 3);
`endif
        press = !fb;
        lost  = !fl && phase >= 2;
        if (phase != 0 && (press || lost)) begin
            phase   = 0;
            m_cause = press ? 1 : 2;
            if (lost && m_cnt < 255) m_cnt++;
        end else if (phase == 0) begin
            if (fb) phase = 1;
        end else if (phase == 1) begin
            if (fl) begin
                phase = 2;
                str_n = 0;
            end
        end else if (phase == 2) begin
            if (str_n == STR - 1) phase = 3;
            else str_n++;
        end
        sb = bp[SYNC-1];
        sl = lp[SYNC-1];
        filt(fb, rb, sb, DEB, DEB);
        filt(fl, rl, sl, LCK, 1);
        for (int i = SYNC - 1; i > 0; i--) begin
            bp[i] = bp[i-1];
            lp[i] = lp[i-1];
        end
        bp[0] = button_n;
        lp[0] = pll_lock;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else m_step();
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("core_reset", {31'd0, core_reset}, {31'd0, m_core});
        chk("ddr_clk_en", {31'd0, ddr_clk_en}, {31'd0, m_ddr});
        chk("led0", {31'd0, led0}, {31'd0, m_led});
        chk("rst_cause", {30'd0, rst_cause}, m_cause);
        chk("lock_loss_cnt", {24'd0, lock_loss_cnt}, m_cnt);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0: return core_reset;
            1: return ddr_clk_en;
            default: return led0;
        endcase
    endfunction

    task automatic wait_sig(input string name, input int sel, input logic val,
                            input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pick(sel) !== val && n < max);
        checks++;
        if (pick(sel) !== val) begin
            errors++;
            $display("FAIL %s: timeout after %0d cycles, got %b expected %b",
                     name, n, pick(sel), val);
        end
        #1;
    endtask

    int n, hi;

    initial begin
        m_reset();
        #1 rst = 1'b1;
        pll_lock = 1'b1;
        button_n = 1'b1;
        @(negedge clk);
        chk("rst_core", {31'd0, core_reset}, 1);
        chk("rst_ddr", {31'd0, ddr_clk_en}, 0);
        chk("rst_cause0", {30'd0, rst_cause}, 0);
        chk("rst_cnt0", {24'd0, lock_loss_cnt}, 0);
        #1;
        cyc(2);
        rst = 1'b0;

        // power-on sequence
        wait_sig("t1_ddr_rise", 1, 1'b1, 100, n);
        chk("t1_ddr_latency", n, 8);
        wait_sig("t1_core_fall", 0, 1'b0, 100, n);
        chk("t1_stretch_len", n, STR);
        chk("t1_cause", {30'd0, rst_cause}, 0);
        cyc(2);
`ifndef SYS_RST_HEARTBEAT_EN
        chk("t6_led_run", {31'd0, led0}, 1);
`endif

        // short press ignored, long press re-sequences
        button_n = 1'b0;
        cyc(5);
        button_n = 1'b1;
        cyc(20);
        chk("t2_short_press", {31'd0, core_reset}, 0);
        button_n = 1'b0;
        cyc(14);
        chk("t2_core", {31'd0, core_reset}, 1);
        chk("t2_ddr", {31'd0, ddr_clk_en}, 0);
        chk("t2_cause", {30'd0, rst_cause}, 1);
        cyc(10);
        chk("t2_held", {31'd0, core_reset}, 1);
        button_n = 1'b1;
        wait_sig("t2_resequence", 0, 1'b0, 100, n);

        // lock loss, then glitches in WAIT_LOCK
        cyc(3);
        pll_lock = 1'b0;
        cyc(1);
        pll_lock = 1'b1;
        cyc(2);
        pll_lock = 1'b0;
        cyc(4);
        chk("t3_core", {31'd0, core_reset}, 1);
        chk("t3_ddr", {31'd0, ddr_clk_en}, 0);
        chk("t3_cause", {30'd0, rst_cause}, 2);
        chk("t3_cnt", {24'd0, lock_loss_cnt}, 1);
        cyc(10);
        pll_lock = 1'b1;
        cyc(3);
        pll_lock = 1'b0;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (ddr_clk_en) hi++;
        end
        chk("t3_glitch_ddr", hi, 0);
        pll_lock = 1'b1;
        wait_sig("t3_resequence", 0, 1'b0, 100, n);

        // press and lock loss hitting the filters together
        cyc(3);
        button_n = 1'b0;
        cyc(7);
        pll_lock = 1'b0;
        cyc(6);
        chk("t4_cause", {30'd0, rst_cause}, 1);
        chk("t4_cnt", {24'd0, lock_loss_cnt}, 2);
        button_n = 1'b1;
        pll_lock = 1'b1;
        wait_sig("t4_resequence", 0, 1'b0, 100, n);

        // random stimulus
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                cyc($urandom_range(1, 3));
                rst = 1'b0;
            end else begin
                button_n = ($urandom_range(0, 3) != 0);
                pll_lock = ($urandom_range(0, 3) != 0);
                cyc($urandom_range(1, 30));
            end
        end

        // saturation of the lock-loss counter
        button_n = 1'b1;
        pll_lock = 1'b1;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            pll_lock = 1'b1;
            cyc(12);
            pll_lock = 1'b0;
            cyc(3);
        end
        chk("t5_saturate", {24'd0, lock_loss_cnt}, 255);

        // async reset mid-STRETCH
        pll_lock = 1'b1;
        wait_sig("t5_stretch", 1, 1'b1, 100, n);
        cyc(3);
        chk("t5_in_stretch", {31'd0, core_reset}, 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_core", {31'd0, core_reset}, 1);
        chk("t5_rst_ddr", {31'd0, ddr_clk_en}, 0);
        chk("t5_rst_led", {31'd0, led0}, 0);
        chk("t5_rst_cause", {30'd0, rst_cause}, 0);
        chk("t5_rst_cnt", {24'd0, lock_loss_cnt}, 0);
        cyc(2);
        rst = 1'b0;
        wait_sig("t6_run", 0, 1'b0, 100, n);

`ifdef SYS_RST_HEARTBEAT_EN
        wait_sig("t6_led_high", 2, 1'b1, 40, n);
        wait_sig("t6_led_low", 2, 1'b0, 40, n);
        chk("t6_led_period", n, 8);
`else
        cyc(5);
        chk("t6_led_steady", {31'd0, led0}, 1);
`endif
        cyc(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
